// File: rtl/and_pkg.sv
// Shared types and constants for the AND-gate stimulus sequencer.
package and_pkg;

    // Sequencer states; the encoding is visible on the debug port.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DRIVE = 2'b01,
        FIN   = 2'b10
    } state_t;

    // Entries in the 2-input truth table (00,01,10,11).
    localparam int NUM_VECS = 4;

    // Ceiling of the mismatch counter.
    localparam logic [7:0] ERR_MAX = 8'd255;

    // Saturating increment for the mismatch counter.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == ERR_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/and_dwell_ctr.sv
// Dwell counter: counts cycles a vector has been held and flags the last one.
// o_tc is high on the final dwell cycle while counting is enabled.
module and_dwell_ctr #(
    parameter int DWELL = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [7:0] TC_VAL = 8'(DWELL - 1);

    logic [7:0] r_cnt;

    assign o_tc = i_en && (r_cnt == TC_VAL);

    // Count while enabled; wrap to zero on terminal count or explicit clear.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= 8'd0;
        end else if (o_tc) begin
            r_cnt <= 8'd0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/and_stim_seq.sv
// Stimulus sequencer for a 2-input AND gate: walks {a,b} through 00,01,10,11,
// DWELL cycles per vector, NUM_PASSES times per start, then pulses done.
// Optional feature macro: AND_CHECK_EN adds the c_in feedback checker
// (err_cnt, pass).
//
// Handshake: start is a level sampled only in IDLE; a start seen there
// launches a run on the next edge, and starts during DRIVE/FIN are dropped.
// busy marks the driving window, done is a single-cycle completion strobe.
module and_stim_seq
    import and_pkg::*;
#(
    parameter int DWELL      = 5,
    parameter int NUM_PASSES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic [1:0] vec_idx,
    output logic       busy,
    output logic       done,
`ifdef AND_CHECK_EN
    input  logic       c_in,
    output logic [7:0] err_cnt,
    output logic       pass,
`endif
    output state_t     dbg_state
);

    localparam logic [1:0] LAST_VEC  = 2'(NUM_VECS - 1);
    localparam logic [3:0] LAST_PASS = 4'(NUM_PASSES - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_vec;
    logic [1:0] w_vec_nxt;
    logic [3:0] r_pass;
    logic [3:0] w_pass_nxt;
    logic       r_busy;
    logic       r_done;
    logic       w_dwell_clr;
    logic       w_dwell_en;
    logic       w_tc;

    and_dwell_ctr #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_dwell_clr),
        .i_en  (w_dwell_en),
        .o_tc  (w_tc)
    );

    // Next-state logic: vector advance on terminal count, pass counting on wrap.
    always_comb begin
        w_state_nxt = r_state;
        w_vec_nxt   = r_vec;
        w_pass_nxt  = r_pass;
        w_dwell_clr = 1'b0;
        w_dwell_en  = 1'b0;
        case (r_state)
            IDLE: begin
                w_vec_nxt = 2'd0;
                if (start) begin
                    w_state_nxt = DRIVE;
                    w_pass_nxt  = 4'd0;
                    w_dwell_clr = 1'b1;
                end
            end
            DRIVE: begin
                w_dwell_en = 1'b1;
                if (w_tc) begin
                    if (r_vec == LAST_VEC && r_pass == LAST_PASS) begin
                        // Final vector stays on {a,b} through the FIN cycle.
                        w_state_nxt = FIN;
                    end else begin
                        w_vec_nxt = r_vec + 2'd1;
                        if (r_vec == LAST_VEC) begin
                            w_pass_nxt = r_pass + 4'd1;
                        end
                    end
                end
            end
            FIN: begin
                w_state_nxt = IDLE;
                w_vec_nxt   = 2'd0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_vec_nxt   = 2'd0;
            end
        endcase
    end

    // State and output registers; busy/done are registered from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_vec   <= 2'd0;
            r_pass  <= 4'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_vec   <= w_vec_nxt;
            r_pass  <= w_pass_nxt;
            r_busy  <= (w_state_nxt == DRIVE);
            r_done  <= (w_state_nxt == FIN);
        end
    end

    assign a         = r_vec[1];
    assign b         = r_vec[0];
    assign vec_idx   = r_vec;
    assign busy      = r_busy;
    assign done      = r_done;
    assign dbg_state = r_state;

`ifdef AND_CHECK_EN
    logic [7:0] r_err;

    // Compare gate output on each vector's last dwell cycle; clear on launch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 8'd0;
        end else if (r_state == IDLE && w_state_nxt == DRIVE) begin
            r_err <= 8'd0;
        end else if (r_state == DRIVE && w_tc && (c_in != (r_vec[1] & r_vec[0]))) begin
            r_err <= sat_inc(r_err);
        end
    end

    assign err_cnt = r_err;
    assign pass    = r_done && (r_err == 8'd0);
`endif

endmodule

// File: tb/tb_and_stim_seq.sv
// Bench for and_stim_seq: two instances (DWELL=5/PASSES=1, DWELL=1/PASSES=2)
// share start/rst, a cycle-count model predicts every output each cycle.
module tb_and_stim_seq;
    import and_pkg::*;

    localparam int D0 = 5;
    localparam int P0 = 1;
    localparam int D1 = 1;
    localparam int P1 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start;
    logic       a_o    [2];
    logic       b_o    [2];
    logic [1:0] vec_o  [2];
    logic       busy_o [2];
    logic       done_o [2];
    state_t     st_o   [2];

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // Model: cycles since launch (0 = idle), per instance.
    int m_t [2];

`ifdef AND_CHECK_EN
    logic       c_in_w [2];
    logic [7:0] err_o  [2];
    logic       pass_o [2];
    int         m_err  [2];
    int         c_mode;
    logic       c_rnd;
    assign c_in_w[0] = (c_mode == 0) ? (a_o[0] & b_o[0]) : (c_mode == 1) ? 1'b1 : c_rnd;
    assign c_in_w[1] = (c_mode == 0) ? (a_o[1] & b_o[1]) : (c_mode == 1) ? 1'b1 : c_rnd;
`endif

    and_stim_seq #(.DWELL(D0), .NUM_PASSES(P0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a_o[0]),
        .b         (b_o[0]),
        .vec_idx   (vec_o[0]),
        .busy      (busy_o[0]),
        .done      (done_o[0]),
`ifdef AND_CHECK_EN
        .c_in      (c_in_w[0]),
        .err_cnt   (err_o[0]),
        .pass      (pass_o[0]),
`endif
        .dbg_state (st_o[0])
    );

    and_stim_seq #(.DWELL(D1), .NUM_PASSES(P1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a_o[1]),
        .b         (b_o[1]),
        .vec_idx   (vec_o[1]),
        .busy      (busy_o[1]),
        .done      (done_o[1]),
`ifdef AND_CHECK_EN
        .c_in      (c_in_w[1]),
        .err_cnt   (err_o[1]),
        .pass      (pass_o[1]),
`endif
        .dbg_state (st_o[1])
    );

    function automatic int dw(input int i);
        return (i == 0) ? D0 : D1;
    endfunction

    function automatic int nb(input int i);
        return 4 * dw(i) * ((i == 0) ? P0 : P1);
    endfunction

    // Vector on {a,b}: index of the table entry for busy cycle t, 11 in FIN.
    function automatic logic [1:0] exp_vec(input int i);
        if (m_t[i] >= 1 && m_t[i] <= nb(i)) return 2'(((m_t[i] - 1) / dw(i)) % 4);
        if (m_t[i] == nb(i) + 1) return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic exp_busy(input int i);
        return (m_t[i] >= 1 && m_t[i] <= nb(i));
    endfunction

    function automatic logic exp_done(input int i);
        return (m_t[i] == nb(i) + 1);
    endfunction

    function automatic state_t exp_state(input int i);
        if (m_t[i] == 0) return IDLE;
        if (m_t[i] <= nb(i)) return DRIVE;
        return FIN;
    endfunction

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, i, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, then advance the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                logic [1:0] ev;
                ev = exp_vec(i);
                chk("a", i, 32'(a_o[i]), 32'(ev[1]));
                chk("b", i, 32'(b_o[i]), 32'(ev[0]));
                chk("vec_idx", i, 32'(vec_o[i]), 32'(ev));
                chk("busy", i, 32'(busy_o[i]), 32'(exp_busy(i)));
                chk("done", i, 32'(done_o[i]), 32'(exp_done(i)));
                chk("state", i, 32'(st_o[i]), 32'(exp_state(i)));
`ifdef AND_CHECK_EN
                chk("err_cnt", i, 32'(err_o[i]), 32'(m_err[i]));
                chk("pass", i, 32'(pass_o[i]), 32'(exp_done(i) && m_err[i] == 0));
`endif
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_t[i] = 0;
`ifdef AND_CHECK_EN
                m_err[i] = 0;
`endif
            end else if (m_t[i] == 0) begin
                if (start) begin
                    m_t[i] = 1;
`ifdef AND_CHECK_EN
                    m_err[i] = 0;
`endif
                end
            end else if (m_t[i] <= nb(i)) begin
`ifdef AND_CHECK_EN
                if ((m_t[i] % dw(i)) == 0 && (c_in_w[i] != (exp_vec(i) == 2'd3)) && m_err[i] < 255)
                    m_err[i]++;
`endif
                m_t[i]++;
            end else begin
                m_t[i] = 0;
            end
        end
    end

    logic [1:0] cap_vec [64];
    int         cap_busy;
    int         cap_done;
    logic [7:0] cap_err;
    logic [7:0] cap_err1;
    logic       cap_pass;

    // Launch one run and record instance i's busy vectors and done timing.
    task automatic run_seq(input int i, input bit extra, input int rst_at, input int limit);
        int cyc;
        cyc      = 0;
        cap_busy = 0;
        cap_done = 0;
        cap_err  = 8'd0;
        cap_err1 = 8'd0;
        cap_pass = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        while (cyc < limit && cap_done == 0) begin
            @(negedge clk);
            cyc++;
            if (busy_o[i]) begin
                if (cap_busy < 64) cap_vec[cap_busy] = vec_o[i];
                cap_busy++;
            end
`ifdef AND_CHECK_EN
            if (cyc == 1) cap_err1 = err_o[i];
            if (done_o[i]) begin
                cap_err  = err_o[i];
                cap_pass = pass_o[i];
            end
`endif
            if (done_o[i]) cap_done = cyc;
            @(posedge clk);
            #1;
            start = extra && (cyc == 2 || cyc == 9);
            rst   = (rst_at > 0) && (cyc == rst_at - 1);
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic wait_idle;
        int k;
        k = 0;
        @(negedge clk);
        while ((busy_o[0] | busy_o[1] | done_o[0] | done_o[1]) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("idle_timeout", 0, 32'(k >= 200), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] seq;
        rst   = 1'b1;
        start = 1'b0;
        m_t[0] = 0;
        m_t[1] = 0;
`ifdef AND_CHECK_EN
        m_err[0] = 0;
        m_err[1] = 0;
        c_mode   = 0;
        c_rnd    = 1'b0;
`endif
        @(posedge clk);
        #1 chk_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_busy", i, 32'(busy_o[i]), 32'd0);
            chk("rst_done", i, 32'(done_o[i]), 32'd0);
            chk("rst_vec", i, 32'(vec_o[i]), 32'd0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        wait_idle();

        // Full table, DWELL=5: 20 busy cycles, done on cycle 21.
        run_seq(0, 1'b0, 0, 200);
        chk("s1_busy_cycles", 0, 32'(cap_busy), 32'd20);
        chk("s1_done_cycle", 0, 32'(cap_done), 32'd21);
        chk("s1_vec_c5", 0, 32'(cap_vec[4]), 32'd0);
        chk("s1_vec_c6", 0, 32'(cap_vec[5]), 32'd1);
        chk("s1_vec_c11", 0, 32'(cap_vec[10]), 32'd2);
        chk("s1_vec_c20", 0, 32'(cap_vec[19]), 32'd3);
`ifdef AND_CHECK_EN
        chk("s5_err", 0, 32'(cap_err), 32'd0);
        chk("s5_pass", 0, 32'(cap_pass), 32'd1);
`endif
        wait_idle();

        // DWELL=1, two passes: 0,1,2,3,0,1,2,3 then done.
        run_seq(1, 1'b0, 0, 200);
        seq = 16'd0;
        for (int k = 0; k < 8; k++) seq = {seq[13:0], cap_vec[k]};
        chk("s2_busy_cycles", 1, 32'(cap_busy), 32'd8);
        chk("s2_done_cycle", 1, 32'(cap_done), 32'd9);
        chk("s2_vec_seq", 1, 32'(seq), 32'h1B1B);
        wait_idle();

        // Extra start pulses mid-run are ignored.
        run_seq(0, 1'b1, 0, 200);
        chk("s3_busy_cycles", 0, 32'(cap_busy), 32'd20);
        chk("s3_done_cycle", 0, 32'(cap_done), 32'd21);
        wait_idle();

        // Reset during busy cycle 7: run aborts with no done pulse.
        run_seq(0, 1'b0, 7, 40);
        chk("s4_busy_cycles", 0, 32'(cap_busy), 32'd7);
        chk("s4_no_done", 0, 32'(cap_done), 32'd0);
        wait_idle();
        run_seq(0, 1'b0, 0, 200);
        chk("s4_rerun_done", 0, 32'(cap_done), 32'd21);
        wait_idle();

`ifdef AND_CHECK_EN
        // c_in stuck high: vectors 00,01,10 mismatch on every pass.
        c_mode = 1;
        run_seq(0, 1'b0, 0, 200);
        chk("s6_err", 0, 32'(cap_err), 32'd3);
        chk("s6_pass", 0, 32'(cap_pass), 32'd0);
        wait_idle();
        run_seq(1, 1'b0, 0, 200);
        chk("s6_err_2pass", 1, 32'(cap_err), 32'd6);
        wait_idle();
        c_mode = 0;
        run_seq(0, 1'b0, 0, 200);
        chk("s6_err_cleared", 0, 32'(cap_err1), 32'd0);
        chk("s6_pass_after", 0, 32'(cap_pass), 32'd1);
        wait_idle();
`endif

        // Random start/reset/gate-feedback traffic, checked by the model.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            start = ($urandom_range(0, 3) == 0);
            rst   = ($urandom_range(0, 299) == 0);
`ifdef AND_CHECK_EN
            c_rnd = 1'($urandom_range(0, 1));
            if ((c % 200) == 0) c_mode = $urandom_range(0, 2);
`endif
        end
        start = 1'b0;
        rst   = 1'b0;
        wait_idle();
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
